// File: rtl/alu_operand_stage.sv
// Operand fetch / issue stage feeding the 8-bit ALU.
// Owns the register file, carry flag and pending-write scoreboard.
module alu_operand_stage #(
  parameter int NREGS = 8,
  parameter int DW    = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_cmd,
  input  logic [AW-1:0] in_ra,
  input  logic [AW-1:0] in_rb,
  input  logic          in_use_imm,
  input  logic [DW-1:0] in_imm,
  input  logic [AW-1:0] in_rd,
  input  logic          in_wr_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    alu_cmd,
  output logic [DW-1:0] inA,
  output logic [DW-1:0] inB,
  output logic          sc_i,
  output logic [AW-1:0] out_rd,
  output logic          out_wr_en,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic          wb_sc_en,
  input  logic          wb_sc
);

  logic [DW-1:0]    regs [NREGS];
  logic             carry;
  logic [NREGS-1:0] pending;
  logic             pending_c;

  logic [NREGS-1:0] wb_dec;
  logic [NREGS-1:0] set_dec;
  logic [NREGS-1:0] pend_v;
  logic             adv;
  logic             accept;
  logic             hazard;
  logic             is_add;
  logic [DW-1:0]    rd_a;
  logic [DW-1:0]    rd_b;
  logic [DW-1:0]    op_b;
  logic             c_rd;

  // Writeback one-hot, used for both bypass and scoreboard clear.
  always_comb begin
    wb_dec = '0;
    if (wb_en) wb_dec[wb_rd] = 1'b1;
  end

  // Scoreboard set vector for an accepted writing instruction.
  always_comb begin
    set_dec = '0;
    if (accept && in_wr_en) set_dec[in_rd] = 1'b1;
  end

  assign is_add = (in_cmd == 3'b111);
  assign pend_v = pending & ~wb_dec;
  assign adv    = !out_valid || out_ready;

  assign hazard = in_valid && (
      pend_v[in_ra]
    || (!in_use_imm && pend_v[in_rb])
    || (in_wr_en && pend_v[in_rd])
    || (is_add && pending_c && !wb_sc_en));

  assign in_ready = adv && !hazard;
  assign accept   = in_valid && in_ready;

  assign rd_a = wb_dec[in_ra] ? wb_data : regs[in_ra];
  assign rd_b = wb_dec[in_rb] ? wb_data : regs[in_rb];
  assign op_b = in_use_imm ? in_imm : rd_b;
  assign c_rd = wb_sc_en ? wb_sc : carry;

  // Register file and carry: writeback never stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      carry <= 1'b0;
    end else begin
      if (wb_en) regs[wb_rd] <= wb_data;
      if (wb_sc_en) carry <= wb_sc;
    end
  end

  // Pending bits: a new issue overrides a same-cycle writeback clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      pending_c <= 1'b0;
    end else begin
      pending   <= (pending & ~wb_dec) | set_dec;
      pending_c <= (pending_c && !wb_sc_en) || (accept && is_add);
    end
  end

  // Output pipeline register toward the ALU.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_cmd   <= '0;
      inA       <= '0;
      inB       <= '0;
      sc_i      <= 1'b0;
      out_rd    <= '0;
      out_wr_en <= 1'b0;
    end else if (adv) begin
      out_valid <= accept;
      if (accept) begin
        alu_cmd   <= in_cmd;
        inA       <= rd_a;
        inB       <= op_b;
        sc_i      <= c_rd;
        out_rd    <= in_rd;
        out_wr_en <= in_wr_en;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage.
// Directed scenarios then randomized traffic vs a reference model.
module tb_alu_operand_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_cmd;
  logic [2:0] in_ra;
  logic [2:0] in_rb;
  logic       in_use_imm;
  logic [7:0] in_imm;
  logic [2:0] in_rd;
  logic       in_wr_en;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] alu_cmd;
  logic [7:0] inA;
  logic [7:0] inB;
  logic       sc_i;
  logic [2:0] out_rd;
  logic       out_wr_en;
  logic       wb_en;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       wb_sc_en;
  logic       wb_sc;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_ra(in_ra), .in_rb(in_rb),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_rd(in_rd), .in_wr_en(in_wr_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .sc_i(sc_i),
    .out_rd(out_rd), .out_wr_en(out_wr_en),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_sc_en(wb_sc_en), .wb_sc(wb_sc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
    logic       sc;
    logic [2:0] rd;
    logic       wr;
  } exp_t;

  exp_t q[$];

  int n_pass = 0;
  int n_tot  = 0;

  logic [7:0] m_regs [8];
  bit         m_pend [8];
  bit         m_c, m_pc, m_ov;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
  endtask

  function automatic logic [7:0] rdv(input logic [2:0] a);
    return (wb_en && wb_rd == a) ? wb_data : m_regs[a];
  endfunction

  function automatic bit pnd(input logic [2:0] a);
    return m_pend[a] && !(wb_en && wb_rd == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 8'h00;
      m_pend[i] = 1'b0;
    end
    m_c  = 1'b0;
    m_pc = 1'b0;
    m_ov = 1'b0;
    q.delete();
  endtask

  task automatic idle();
    rst_n = 1'b1; in_valid = 1'b0; in_cmd = '0;
    in_ra = '0; in_rb = '0; in_use_imm = 1'b0;
    in_imm = '0; in_rd = '0; in_wr_en = 1'b0;
    out_ready = 1'b1; wb_en = 1'b0; wb_rd = '0;
    wb_data = '0; wb_sc_en = 1'b0; wb_sc = 1'b0;
  endtask

  // One clock: check handshake, push expectation, advance model.
  task automatic step();
    bit   hz, adv, rdy, acc;
    exp_t e;
    @(negedge clk);
    hz = in_valid && (pnd(in_ra)
       || (!in_use_imm && pnd(in_rb))
       || (in_wr_en && pnd(in_rd))
       || (in_cmd == 3'b111 && m_pc && !wb_sc_en));
    adv = !m_ov || out_ready;
    rdy = adv && !hz;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, m_ov);
    acc = rst_n && in_valid && rdy;
    if (acc) begin
      e.cmd = in_cmd;
      e.a   = rdv(in_ra);
      e.b   = in_use_imm ? in_imm : rdv(in_rb);
      e.sc  = wb_sc_en ? wb_sc : m_c;
      e.rd  = in_rd;
      e.wr  = in_wr_en;
      q.push_back(e);
    end
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      if (wb_en) begin
        m_regs[wb_rd] = wb_data;
        m_pend[wb_rd] = 1'b0;
      end
      if (wb_sc_en) begin
        m_c  = wb_sc;
        m_pc = 1'b0;
      end
      if (acc && in_wr_en) m_pend[in_rd] = 1'b1;
      if (acc && in_cmd == 3'b111) m_pc = 1'b1;
      if (adv) m_ov = acc;
    end
    #1;
  endtask

  task automatic rand_in();
    int k;
    rst_n      = ($urandom_range(0, 299) != 0);
    in_valid   = ($urandom_range(0, 3) != 0);
    in_cmd     = 3'($urandom);
    in_ra      = 3'($urandom);
    in_rb      = 3'($urandom);
    in_use_imm = 1'($urandom);
    in_imm     = 8'($urandom);
    in_rd      = 3'($urandom);
    in_wr_en   = 1'($urandom);
    out_ready  = ($urandom_range(0, 3) != 0);
    wb_en      = ($urandom_range(0, 2) != 0);
    wb_rd      = 3'($urandom);
    k          = $urandom_range(0, 7);
    for (int i = 0; i < 8; i++)
      if (m_pend[(k + i) % 8] && $urandom_range(0, 1) == 1)
        wb_rd = 3'((k + i) % 8);
    wb_data    = 8'($urandom);
    wb_sc_en   = ($urandom_range(0, 3) == 0);
    wb_sc      = 1'($urandom);
  endtask

  // Monitor: pop on every fire and verify stalls hold outputs.
  initial begin
    exp_t       e;
    bit         hold_p = 1'b0;
    logic [2:0] s_cmd, s_rd;
    logic [7:0] s_a, s_b;
    logic       s_sc, s_wr;
    forever begin
      @(negedge clk);
      if (hold_p) begin
        chk("hold_cmd", alu_cmd, s_cmd);
        chk("hold_a", inA, s_a);
        chk("hold_b", inB, s_b);
        chk("hold_sc", sc_i, s_sc);
        chk("hold_rd", out_rd, s_rd);
        chk("hold_wr", out_wr_en, s_wr);
      end
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) chk("q_underflow", 1, 0);
        else begin
          e = q.pop_front();
          chk("alu_cmd", alu_cmd, e.cmd);
          chk("inA", inA, e.a);
          chk("inB", inB, e.b);
          chk("sc_i", sc_i, e.sc);
          chk("out_rd", out_rd, e.rd);
          chk("out_wr_en", out_wr_en, e.wr);
        end
      end
      hold_p = rst_n && out_valid && !out_ready;
      s_cmd = alu_cmd; s_a = inA; s_b = inB;
      s_sc = sc_i; s_rd = out_rd; s_wr = out_wr_en;
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cmd", alu_cmd, 0);
    chk("rst_inA", inA, 0);
    chk("rst_inB", inB, 0);
    chk("rst_sc", sc_i, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_wr", out_wr_en, 0);
    idle();
    for (int i = 0; i < 8; i++) begin
      idle(); in_valid = 1'b1; in_ra = 3'(i);
      in_rb = 3'(7 - i); step();
    end
    idle(); step(); step();

    idle(); wb_en = 1'b1; wb_rd = 3'd3; wb_data = 8'h5A; step();
    idle(); in_valid = 1'b1; in_cmd = 3'b011; in_ra = 3'd3;
    in_use_imm = 1'b1; in_imm = 8'h0F; step();
    #1;
    chk("t2_inA", inA, 8'h5A);
    chk("t2_inB", inB, 8'h0F);
    chk("t2_valid", out_valid, 1);
    idle(); step();

    idle(); in_valid = 1'b1; in_cmd = 3'b111; in_ra = 3'd0;
    in_rb = 3'd1; in_rd = 3'd2; in_wr_en = 1'b1; step();
    idle(); in_valid = 1'b1; in_cmd = 3'b001; in_ra = 3'd2;
    in_rb = 3'd0; in_rd = 3'd4; in_wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_stall", in_ready, 0);
      step();
    end
    wb_en = 1'b1; wb_rd = 3'd2; wb_data = 8'h11;
    #1 chk("t3_bypass_rdy", in_ready, 1);
    step();
    #1 chk("t3_inA", inA, 8'h11);
    idle(); wb_en = 1'b1; wb_rd = 3'd4; wb_sc_en = 1'b1; step();

    idle(); in_valid = 1'b1; in_cmd = 3'b010; in_ra = 3'd1;
    in_use_imm = 1'b1; in_imm = 8'hC3; out_ready = 1'b0; step();
    in_cmd = 3'b100; in_imm = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_stall", in_ready, 0);
      step();
    end
    out_ready = 1'b1; step();
    #1 chk("t4_next_B", inB, 8'h3C);
    idle(); step();

    idle(); in_valid = 1'b1; in_cmd = 3'b111; step();
    idle(); in_valid = 1'b1; in_cmd = 3'b111; in_ra = 3'd1;
    in_use_imm = 1'b1; wb_sc_en = 1'b1; wb_sc = 1'b1; step();
    #1 chk("t5_sc", sc_i, 1);
    idle(); in_valid = 1'b1; in_cmd = 3'b111; in_use_imm = 1'b1;
    #1 chk("t5_pend_c", in_ready, 0);
    step();
    wb_sc_en = 1'b1; wb_sc = 1'b0; step();
    #1 chk("t5_sc0", sc_i, 0);
    idle(); step();

    idle(); in_valid = 1'b1; in_cmd = 3'b001; in_rd = 3'd5;
    in_wr_en = 1'b1; out_ready = 1'b0; step();
    idle(); rst_n = 1'b0; out_ready = 1'b0; step();
    idle(); in_valid = 1'b1; in_ra = 3'd5; in_rb = 3'd5;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_ready", in_ready, 1);
    step();
    idle(); step();

    for (int i = 0; i < 3000; i++) begin
      rand_in();
      step();
    end

    idle();
    repeat (4) step();
    chk("drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
